// File: rtl/fir_accumulator_pkg.sv
// Shared types, widths and arithmetic helpers for the FIR output accumulator.
package fir_accumulator_pkg;

  localparam int ACC_W     = 57;  // 10.47 accumulator: 52-bit product plus 5 guard bits
  localparam int FRAC_DROP = 24;  // LSBs removed by rounding, 10.47 -> 10.23
  localparam int OUT_W     = 32;  // signed 9.23 output rail
  localparam int PP_W      = 52;  // signed 5.47 partial product rail
  localparam int RND_W     = ACC_W - FRAC_DROP + 1;  // rounded value incl. carry bit

  // One half output LSB, in the one-bit-wider rounding domain.
  localparam logic [ACC_W:0] RND_HALF =
    {{(ACC_W - FRAC_DROP + 1){1'b0}}, 1'b1, {(FRAC_DROP - 1){1'b0}}};

  typedef struct packed {
    logic signed [PP_W-1:0] i;
    logic signed [PP_W-1:0] q;
  } Partial_product;

  typedef struct packed {
    logic signed [OUT_W-1:0] i;
    logic signed [OUT_W-1:0] q;
  } Out_sample;

  typedef struct packed {
    Out_sample sample;
    logic      sat;
  } fifo_entry_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] value;
    logic                    sat;
  } rail_result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  function automatic logic signed [ACC_W-1:0] sext_pp(input logic signed [PP_W-1:0] v);
    return {{(ACC_W - PP_W){v[PP_W-1]}}, v};
  endfunction

  // Round half toward +inf, then clamp to the signed OUT_W range.
  // The bias add is done one bit wider so a near-full-scale sum cannot wrap.
  function automatic rail_result_t round_sat(input logic signed [ACC_W-1:0] sum);
    logic [ACC_W:0]       biased;
    logic [RND_W-1:0]     rounded;
    logic [RND_W-OUT_W:0] upper;
    rail_result_t         r;
    biased  = {sum[ACC_W-1], sum} + RND_HALF;
    rounded = RND_W'(biased >> FRAC_DROP);
    upper   = rounded[RND_W-1:OUT_W-1];
    r.sat   = !((&upper) || !(|upper));
    if (!r.sat)
      r.value = rounded[OUT_W-1:0];
    else if (upper[RND_W-OUT_W])
      r.value = {1'b1, {(OUT_W - 1){1'b0}}};
    else
      r.value = {1'b0, {(OUT_W - 1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/fir_accumulator_out_skid_fifo.sv
// Two-entry output buffer: push/full on the write side, valid/ready on the read side.
// The head entry is a register, so the read data comes straight from flops.
module out_skid_fifo
  import fir_accumulator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  output logic        full,
  output logic        pop_valid,
  input  logic        pop_ready,
  output fifo_entry_t pop_data
);

  logic [1:0]  count;
  fifo_entry_t head;
  fifo_entry_t tail;
  logic        pop;
  logic        push_ok;

  assign pop     = pop_ready && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop);

  // Occupancy and entry shifting; head only changes on a pop or a push into an empty buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign full      = (count == 2'd2);
  assign pop_valid = (count != 2'd0);
  assign pop_data  = head;

endmodule

// File: rtl/fir_accumulator.sv
// Sums framed complex partial products into one rounded, saturated output sample per frame.
//
// state | meaning
// IDLE  | waiting for the first term of a sample
// ACCUM | partial sum held in acc, waiting for more terms or the last one
module fir_accumulator
  import fir_accumulator_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           pp_valid,
  input  logic           pp_first,
  input  logic           pp_last,
  input  Partial_product partialProduct,
  output logic           out_valid,
  input  logic           out_ready,
  output Out_sample      out_sample,
  output logic           sat_flag,
  output logic           overrun,
  output logic           term_err
);

  acc_state_t state;
  acc_state_t state_nxt;

  logic signed [ACC_W-1:0] pp_i, pp_q;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic                    acc_load, acc_add;
  logic                    fin, fin_single, err_set;

  logic                    fin_valid;
  logic signed [ACC_W-1:0] fin_i, fin_q;
  rail_result_t            rs_i_c, rs_q_c;
  logic                    rs_valid;
  fifo_entry_t             rs_entry;

  logic                    fifo_full;
  fifo_entry_t             fifo_head;

  assign pp_i  = sext_pp(partialProduct.i);
  assign pp_q  = sext_pp(partialProduct.q);
  assign sum_i = acc_i + pp_i;
  assign sum_q = acc_q + pp_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Framing decisions. A pp_first while accumulating is a restart: the partial sum is
  // discarded, and if that term is also the last one it finishes as a single-term sample.
  always_comb begin
    state_nxt  = state;
    acc_load   = 1'b0;
    acc_add    = 1'b0;
    fin        = 1'b0;
    fin_single = 1'b0;
    err_set    = 1'b0;
    if (pp_valid) begin
      case (state)
        IDLE: begin
          if (pp_first) begin
            if (pp_last) begin
              fin        = 1'b1;
              fin_single = 1'b1;
            end else begin
              acc_load  = 1'b1;
              state_nxt = ACCUM;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        ACCUM: begin
          if (pp_first) begin
            err_set = 1'b1;
            if (pp_last) begin
              fin        = 1'b1;
              fin_single = 1'b1;
              state_nxt  = IDLE;
            end else begin
              acc_load = 1'b1;
            end
          end else if (pp_last) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            acc_add = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Running partial sum; wraps at ACC_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (acc_load) begin
      acc_i <= pp_i;
      acc_q <= pp_q;
    end else if (acc_add) begin
      acc_i <= sum_i;
      acc_q <= sum_q;
    end
  end

  // Completed frame sum, held for one cycle ahead of rounding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_valid <= 1'b0;
      fin_i     <= '0;
      fin_q     <= '0;
    end else begin
      fin_valid <= fin;
      if (fin) begin
        fin_i <= fin_single ? pp_i : sum_i;
        fin_q <= fin_single ? pp_q : sum_q;
      end
    end
  end

  assign rs_i_c = round_sat(fin_i);
  assign rs_q_c = round_sat(fin_q);

  // Rounded and saturated result, pushed into the output buffer the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_valid <= 1'b0;
      rs_entry <= '0;
    end else begin
      rs_valid <= fin_valid;
      if (fin_valid) begin
        rs_entry.sample.i <= rs_i_c.value;
        rs_entry.sample.q <= rs_q_c.value;
        rs_entry.sat      <= rs_i_c.sat | rs_q_c.sat;
      end
    end
  end

  out_skid_fifo u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rs_valid),
    .push_data (rs_entry),
    .full      (fifo_full),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (fifo_head)
  );

  assign out_sample = fifo_head.sample;
  assign sat_flag   = fifo_head.sat;

  // Sticky error flags; a full buffer only loses the result if nothing is popped that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun  <= 1'b0;
      term_err <= 1'b0;
    end else begin
      if (rs_valid && fifo_full && !(out_valid && out_ready)) overrun <= 1'b1;
      if (err_set) term_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_accumulator.sv
// Directed and randomized checks of fir_accumulator against a plain-arithmetic model.
module tb_fir_accumulator;
  import fir_accumulator_pkg::*;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [31:0] v;
    logic        s;
  } rail_t;

  logic           clk;
  logic           reset;
  logic           pp_valid, pp_first, pp_last;
  Partial_product pp_data;
  logic           out_valid;
  logic           out_ready;
  Out_sample      out_sample;
  logic           sat_flag, overrun, term_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_ready = 0;
  exp_t exp_q[$];

  longint P47, MAXP, MINN;

  fir_accumulator dut (
    .clk            (clk),
    .reset          (reset),
    .pp_valid       (pp_valid),
    .pp_first       (pp_first),
    .pp_last        (pp_last),
    .partialProduct (pp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sample     (out_sample),
    .sat_flag       (sat_flag),
    .overrun        (overrun),
    .term_err       (term_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rounding: wrap to 57 bits, floor((x + 2^23) / 2^24), clamp to int32.
  function automatic rail_t model_rail(input longint sum);
    longint w, r;
    rail_t  res;
    w = (sum <<< 7) >>> 7;
    r = (w + (longint'(1) <<< 23)) >>> 24;
    if (r > 64'sd2147483647) begin
      res.v = 32'h7FFF_FFFF; res.s = 1'b1;
    end else if (r < -64'sd2147483648) begin
      res.v = 32'h8000_0000; res.s = 1'b1;
    end else begin
      res.v = r[31:0]; res.s = 1'b0;
    end
    return res;
  endfunction

  function automatic longint rnd52();
    longint v;
    v = longint'({$urandom, $urandom});
    return (v <<< 12) >>> 12;
  endfunction

  task automatic push_exp(input logic [31:0] i, input logic [31:0] q, input logic sat);
    exp_t e;
    e.i = i; e.q = q; e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic push_model(input longint si, input longint sq);
    rail_t ri, rq;
    ri = model_rail(si);
    rq = model_rail(sq);
    push_exp(ri.v, rq.v, ri.s | rq.s);
  endtask

  // One clock: inputs already driven; handshake sampled at the falling edge.
  task automatic step();
    exp_t e;
    if (rand_ready) out_ready = out_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_i", {32'd0, out_sample.i}, {32'd0, e.i});
        check("out_q", {32'd0, out_sample.q}, {32'd0, e.q});
        check("out_sat", 64'(sat_flag), 64'(e.sat));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint i, input longint q, input bit first, input bit last);
    pp_valid  = 1'b1;
    pp_first  = first;
    pp_last   = last;
    pp_data.i = i[51:0];
    pp_data.q = q[51:0];
    step();
  endtask

  task automatic idle(input int n);
    pp_valid = 1'b0;
    pp_first = 1'b0;
    pp_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain(input int budget);
    rand_ready = 0;
    out_ready  = 1'b1;
    pp_valid   = 1'b0;
    for (int k = 0; k < budget && (exp_q.size() != 0 || out_valid); k++) step();
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    pp_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    longint si, sq, vi, vq;
    int     len;
    bit     ext, sgn;

    P47  = longint'(1) <<< 47;
    MAXP = (longint'(1) <<< 51) - 1;
    MINN = -(longint'(1) <<< 51);

    reset = 1'b1; pp_valid = 0; pp_first = 0; pp_last = 0; pp_data = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sample", 64'(out_sample), 64'd0);
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_term_err", 64'(term_err), 64'd0);
    reset = 1'b0;
    idle(1);

    // Single term, latency of two edges after the last term.
    push_exp(32'h0080_0000, 32'hFF80_0000, 1'b0);
    send(P47, -P47, 1, 1);
    idle(1);
    check("latency_n1", 64'(out_valid), 64'd0);
    idle(1);
    check("latency_n2", 64'(out_valid), 64'd1);
    drain(10);

    // 16 equal terms.
    push_exp(32'h0800_0000, 32'h0000_0000, 1'b0);
    for (int k = 0; k < 16; k++) send(P47, 0, k == 0, k == 15);
    drain(10);

    // Round half toward +inf.
    push_exp(32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    send(3 * (longint'(1) <<< 23), -3 * (longint'(1) <<< 23), 1, 1);
    drain(10);

    // Saturation on I only; Q lands exactly on the negative limit.
    push_exp(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    for (int k = 0; k < 16; k++) send(MAXP, MINN, k == 0, k == 15);
    drain(10);

    // Backpressure: third result is lost.
    push_exp(32'h0080_0000, 32'h0, 1'b0);
    push_exp(32'h0100_0000, 32'h0, 1'b0);
    send(P47, 0, 1, 1);
    send(2 * P47, 0, 1, 1);
    send(3 * P47, 0, 1, 1);
    idle(4);
    check("overrun_set", 64'(overrun), 64'd1);
    drain(10);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Pop in the push cycle of a full buffer: nothing lost.
    do_reset();
    check("overrun_cleared", 64'(overrun), 64'd0);
    push_exp(32'h0080_0000, 32'h0, 1'b0);
    push_exp(32'h0100_0000, 32'h0, 1'b0);
    push_exp(32'h0180_0000, 32'h0, 1'b0);
    send(P47, 0, 1, 1);
    send(2 * P47, 0, 1, 1);
    send(3 * P47, 0, 1, 1);
    idle(1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(2);
    check("no_overrun_pop_push", 64'(overrun), 64'd0);
    drain(10);

    // Stray term in IDLE.
    send(P47, P47, 0, 1);
    idle(5);
    check("stray_term_err", 64'(term_err), 64'd1);
    check("stray_no_output", 64'(out_valid), 64'd0);

    // Restart mid-sample: only the terms after the second pp_first count.
    do_reset();
    push_exp(32'h0180_0000, 32'h0, 1'b0);
    send(5 * P47, 0, 1, 0);
    send(7 * P47, 0, 0, 0);
    send(P47, 0, 1, 0);
    send(2 * P47, 0, 0, 1);
    idle(3);
    check("restart_term_err", 64'(term_err), 64'd1);
    drain(10);

    // Reset with the buffer occupied and a sample in progress.
    send(P47, P47, 1, 1);
    send(P47, 0, 1, 0);
    send(P47, 0, 0, 0);
    send(P47, 0, 0, 0);
    check("pre_reset_occupied", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_i", {32'd0, out_sample.i}, 64'd0);
    check("midrst_out_q", {32'd0, out_sample.q}, 64'd0);
    check("midrst_sat_flag", 64'(sat_flag), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    check("midrst_term_err", 64'(term_err), 64'd0);
    pp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    push_exp(32'h0100_0000, 32'h0080_0000, 1'b0);
    send(P47, P47, 1, 0);
    send(P47, 0, 0, 1);
    drain(10);
    check("post_rst_term_err", 64'(term_err), 64'd0);

    // Randomized legal frames with intermittent backpressure.
    rand_ready = 1;
    out_ready  = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(3, 32);
      ext = ($urandom_range(0, 3) == 0);
      sgn = ($urandom_range(0, 1) != 0);
      si  = 0;
      sq  = 0;
      for (int k = 0; k < len; k++) begin
        if (ext) begin
          vi = sgn ? MAXP : MINN;
          vq = sgn ? MINN : MAXP;
        end else begin
          vi = rnd52();
          vq = rnd52();
        end
        si += vi;
        sq += vq;
        if (k == len - 1) push_model(si, sq);
        send(vi, vq, k == 0, k == len - 1);
      end
      idle($urandom_range(0, 2));
    end
    drain(200);
    check("random_overrun", 64'(overrun), 64'd0);
    check("random_term_err", 64'(term_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_accumulator.md
# fir_accumulator

Accumulates the stream of complex partial products from the complex multiplier stage into one filtered output sample per group of terms. It sits directly downstream of the multiplier. Per output sample it sign-extends and sums the framed I/Q partial products, rounds and saturates the sum to the output format, and delivers it through a 2-entry valid/ready output buffer. The input side cannot be stalled, so lost results and framing errors are reported on sticky flags.

## Interface
- ACC_W, 57: accumulator width per rail (52-bit product + 5 guard bits, 10.47).
- FRAC_DROP, 24: LSBs removed by rounding (10.47 -> 10.23).
- OUT_W, 32: output width per rail, signed 9.23.
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pp_valid  in  1  partialProduct valid this cycle.
- pp_first  in  1  first term of a sample; qualified by pp_valid.
- pp_last  in  1  last term of a sample; qualified by pp_valid; may coincide with pp_first.
- partialProduct  in  Partial_product  I, Q: 52-bit signed, 5.47.
- out_valid  out  1  out_sample holds a result.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_sample  out  Out_sample  I, Q: OUT_W signed.
- sat_flag  out  1  I or Q of out_sample was saturated; travels with the sample.
- overrun  out  1  sticky: a result was dropped because the buffer was full.
- term_err  out  1  sticky: framing violation seen.

## Operation
- States: IDLE, ACCUM.
- IDLE, pp_valid && pp_first: acc <= sext(pp). Go to ACCUM, or to finish if pp_last is also set.
- IDLE, pp_valid && !pp_first: drop the term and set term_err.
- ACCUM, pp_valid && !pp_first: acc <= acc + sext(pp). If pp_last, finish and return to IDLE.
- ACCUM, pp_valid && pp_first: set term_err, discard the partial sum, reload acc from pp. This is a restart.
- Finish: sum = acc + pp (or pp alone for a single term) is latched into a round/sat register.
  - rounded = (sum + 2^(FRAC_DROP-1)) >>> FRAC_DROP, i.e. round half toward +inf.
  - Clamp rounded to [-2^(OUT_W-1), 2^(OUT_W-1)-1], independently per rail.
  - sat_flag = clamp applied on either rail.
- Next cycle the result is pushed into the 2-entry FIFO.
  - If the FIFO is full and no pop happens that cycle, the result is dropped and overrun is set.
  - A push and pop in the same cycle on a full FIFO is legal: the result is accepted, no overrun.
- Arithmetic wraps at ACC_W. The guard bits cover 32 full-scale terms.
- Sticky flags clear only on reset.

## Timing
- Reset values: out_valid=0, out_sample=0, sat_flag=0, overrun=0, term_err=0, acc=0, state=IDLE, FIFO empty.
- Latency: pp_last accepted at edge N -> out_valid=1 after edge N+2 when the FIFO is empty.
- Throughput: one term per cycle. Back-to-back samples are allowed: pp_last at N and pp_first at N+1.
- out_sample and sat_flag are stable while out_valid && !out_ready.
- Reset asserted mid-accumulation or with the FIFO occupied: all state clears asynchronously, and in-flight results are lost. The first pp_first after reset deassertion starts cleanly.
- Registered outputs only; no combinational path from inputs to outputs.

## Structure
- Shared package:
  - Out_sample typedef (I, Q of OUT_W).
  - ACC_W, FRAC_DROP and OUT_W defaults.
  - Existing Partial_product.
- One sub-module: out_skid_fifo, a 2-entry FIFO of {Out_sample, sat_flag} with push/full and valid/ready pop.
- The FSM, accumulator and round/sat register live in fir_accumulator.

## Test plan
- Single term, first=last=1, I=2^47, Q=-2^47 -> two cycles later out_sample I=0x0080_0000, Q=0xFF80_0000, sat_flag=0.
- 16 terms, each I=2^47, Q=0 -> I=0x0800_0000, Q=0.
- Rounding: single term with I=3·2^23 and Q=-3·2^23 -> I=2, Q=-1.
- Saturation: 16 terms of I=2^51-1 and 16 of Q=-2^51 -> I=0x7FFF_FFFF, Q=0x8000_0000, sat_flag=1.
- Backpressure: out_ready=0, three single-term samples 1,2,3 (·2^47) -> overrun=1; raising out_ready yields exactly 0x0080_0000 then 0x0100_0000. Repeat with a pop in the push cycle -> no overrun.
- Framing/reset:
  - pp_valid without pp_first in IDLE -> term_err=1, no output.
  - pp_first mid-sample -> term_err=1; the output equals only the terms after the restart.
  - reset mid-accumulation -> all outputs 0 immediately.
